// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a transmit FIFO in front of the shifter.
// Words come in over a valid/ready handshake, are queued, and are sent as
// start / data (LSB first) / optional parity / stop frames at a runtime
// divisor. When the queue is non-empty at the end of the last stop bit, the
// next frame starts on the following cycle with no idle gap.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [DIV_W-1:0]              Divisor,
    input  logic [DATA_BITS-1:0]          Data,
    input  logic                          Valid,
    output logic                          Ready,
    output logic [$clog2(FIFO_DEPTH):0]   Level,
    output logic                          Busy,
    output logic                          Tx
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(DATA_BITS);

    // Reject parameter combinations the frame logic does not cover.
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 wr_en;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    // The extra MSB on each pointer tells a full queue from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign Ready = ~full;
    assign wr_en = Valid & ~full;
    assign Level = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer advance on write and on pop; both may happen on one edge.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge Clk) begin
        // NOTE: the storage array has no reset; the pointers alone decide
        // which entries are valid, and this keeps it mappable to RAM.
        if (wr_en) mem[wr_ptr[AW-1:0]] <= Data;
    end

    // ---------------------------------------------------------------
    // Frame sequencer
    // ---------------------------------------------------------------
    state_t               state,    state_n;
    logic [DATA_BITS-1:0] shifter,  shifter_n;
    logic                 par_bit,  par_n;
    logic [DIV_W-1:0]     period,   period_n;
    logic [DIV_W-1:0]     baud_cnt, baud_n;
    logic [CNT_W-1:0]     bit_cnt,  bit_n;
    logic                 tx_q,     tx_n;
    logic                 busy_q;
    logic                 baud_done;
    logic                 start_frame;

    assign baud_done = (baud_cnt == '0);

    // Next-state and next-register values for the sequencer.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_n     = state;
        shifter_n   = shifter;
        par_n       = par_bit;
        period_n    = period;
        baud_n      = baud_cnt;
        bit_n       = bit_cnt;
        tx_n        = tx_q;
        start_frame = 1'b0;
        pop         = 1'b0;

        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (!empty) start_frame = 1'b1;
            end
            S_START: begin
                if (baud_done) begin
                    tx_n      = shifter[0];
                    shifter_n = shifter >> 1;
                    bit_n     = CNT_W'(DATA_BITS - 1);
                    state_n   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    if (bit_cnt == '0) begin
                        if (PARITY != 0) begin
                            tx_n    = par_bit;
                            state_n = S_PARITY;
                        end else begin
                            tx_n    = 1'b1;
                            bit_n   = CNT_W'(STOP_BITS - 1);
                            state_n = S_STOP;
                        end
                    end else begin
                        tx_n      = shifter[0];
                        shifter_n = shifter >> 1;
                        bit_n     = bit_cnt - 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_done) begin
                    tx_n    = 1'b1;
                    bit_n   = CNT_W'(STOP_BITS - 1);
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    if (bit_cnt == '0) begin
                        if (!empty) start_frame = 1'b1;
                        else        state_n     = S_IDLE;
                    end else begin
                        bit_n = bit_cnt - 1'b1;
                    end
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = S_IDLE;
            end
        endcase

        // Bit timing: count down from the latched period, reload on expiry.
        if (state != S_IDLE) begin
            baud_n = baud_done ? period : baud_cnt - 1'b1;
        end

        // Frame start (from IDLE or straight out of the last stop bit):
        // take the head word, fix its parity now, latch the divisor.
        if (start_frame) begin
            pop       = 1'b1;
            shifter_n = head;
            par_n     = (^head) ^ (PARITY == 2);
            period_n  = Divisor;
            baud_n    = Divisor;
            tx_n      = 1'b0;
            state_n   = S_START;
        end
    end

    // Sequencer registers; Tx drops to idle-high the moment Reset rises.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            shifter  <= '0;
            par_bit  <= 1'b0;
            period   <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            shifter  <= shifter_n;
            par_bit  <= par_n;
            period   <= period_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            tx_q     <= tx_n;
        end
    end

    // Busy rises with any queue activity and falls on returning to idle empty.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_q <= 1'b0;
        end else if (wr_en || pop) begin
            busy_q <= 1'b1;
        end else if (state_n == S_IDLE && empty) begin
            busy_q <= 1'b0;
        end
    end

    assign Tx   = tx_q;
    assign Busy = busy_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO, runtime baud divisor, configurable data width, parity and stop bits. Sits between a byte-producing core (valid/ready handshake) and the board Tx pin. Generalises the fixed 8N1 transmitter: adds buffering, back-to-back frames with no idle gap, and flow control.

## Interface
- DATA_BITS, 8, data bits per frame, 5..9
- DIV_W, 16, width of the Divisor port
- FIFO_DEPTH, 4, FIFO entries, power of two, >= 2
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, 1 or 2
- Clk  in  1  single clock; all logic on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- Divisor  in  DIV_W  clocks per bit minus 1; sampled only at frame start
- Data  in  DATA_BITS  word to send
- Valid  in  1  Data is offered this cycle
- Ready  out  1  ~full (combinational); write occurs on edge where Valid & Ready
- Level  out  clog2(FIFO_DEPTH)+1  words held in FIFO (excludes word in shifter)
- Busy  out  1  registered; high while FIFO non-empty or a frame is in progress
- Tx  out  1  serial line, idle high

## Operation
- Reset values: Tx=1, Busy=0, Level=0, Ready=1, FSM=IDLE, FIFO pointers 0, bit/baud counters 0.
- FIFO: write on Valid & Ready; pop by FSM only. Write and pop on same edge both occur, Level unchanged. Write ignored when full (Ready=0). Pointers wrap modulo FIFO_DEPTH; full/empty from an extra pointer bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: Tx=1. If FIFO non-empty: pop head into shifter, latch Divisor into bit-period register, load baud counter, Tx<=0, go START.
- Each bit lasts exactly latched Divisor+1 clocks (Divisor=0 -> 1 clock/bit). Baud counter counts down; bit advances on edge where counter==0.
- START -> DATA: Tx<=shifter[0], shift right; bit counter = DATA_BITS-1.
- DATA: LSB first; after last data bit go PARITY if PARITY!=0, else STOP.
- PARITY: Tx = XOR of all data bits (even) or its inverse (odd); parity computed from the word at pop time.
- STOP: Tx=1 for STOP_BITS bit periods. At end of last stop bit: if FIFO non-empty, pop and go START on the same edge (Tx<=0, new Divisor latched; no idle cycle between frames); else go IDLE.
- Divisor changes mid-frame have no effect until the next frame start.
- Busy<=1 on the edge a word is written or popped; Busy<=0 on the edge FSM enters IDLE with FIFO empty and no write on that edge.
- Reset asserted mid-frame: Tx returns high asynchronously, FIFO flushed, partial frame abandoned; no frame resumes after release.
- PARITY outside 0..2 or STOP_BITS outside 1..2: behaviour undefined; elaboration-time assertion recommended.

## Timing
- Accept at edge E0 with FSM IDLE and FIFO empty: pop at E1, Tx low from E1 (one-cycle latency).
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) x (Divisor+1) clocks.
- Back-to-back frames: next start bit begins the cycle after the last stop-bit cycle.
- Capacity: FIFO_DEPTH words plus one in the shifter.
- Ready combinational from registered pointers; no combinational path from Valid to Ready.

## Test plan
- Defaults + PARITY=1, Divisor=3, send 0xA5 -> Tx low from E1 for 4 clocks, then 1,0,1,0,0,1,0,1 for 4 clocks each, parity 0, stop 1 for 4 clocks; 44-clock frame; Busy falls after stop bit.
- PARITY=2, STOP_BITS=2, Divisor=0, send 0x00 -> start 0, eight 0s, parity 1, two 1s; 12-clock frame.
- Valid held high with 6 words 0x01..0x06, Divisor=1 -> words 1..5 accepted (Level peaks at 4), Ready=0 blocks word 6 until first frame pops the next word; all six frames on Tx in order with no idle gap.
- Change Divisor 3 -> 7 mid-frame -> current frame keeps 4 clocks/bit; next frame uses 8 clocks/bit.
- Assert Reset during data bit 3 with 2 words queued -> Tx=1 immediately, Level=0, Busy=0, Ready=1; Tx stays idle after release.
- DATA_BITS=5, PARITY=0, send 5'h13 -> bits 1,1,0,0,1 then stop; Divisor=0 gives 7-clock frame.
